btn_event_ctrl: RTL
===================

BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 The block SHALL have parameter N_BTN, default 4, number of switch channels (legal range 1..4).
REQ-002 The block SHALL have parameter TICK_BITS, default 19, width of the shared sample-tick counter (2^19 x 20 ns = 10 ms).
REQ-003 The block SHALL have parameter DB_TICKS, default 3, number of consecutive ticks a new level must persist (legal range 1..7).
REQ-004 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1 bit, reset (asynchronous, active-high).
REQ-006 The block SHALL have port sw, input, N_BTN bits, raw switch levels, already synchronised to clk.
REQ-007 The block SHALL have port db, output, N_BTN bits, debounced levels.
REQ-008 The block SHALL have port ev_valid, output, 1 bit, event available.
REQ-009 The block SHALL have port ev_ready, input, 1 bit, consumer accepts event.
REQ-010 The block SHALL have port ev_id, output, 2 bits, channel index of the event.
REQ-011 The block SHALL have port ev_rise, output, 1 bit: 1 = press (0->1), 0 = release (1->0).
REQ-012 The block SHALL have port ovf_clr, input, 1 bit, clears ovf.
REQ-013 The block SHALL have port ovf, output, 1 bit, sticky lost-event flag.

Function
REQ-014 One free-running TICK_BITS counter SHALL increment every cycle, wrap from all-ones to 0, and be shared by all channels; tick = (counter == 0).
REQ-015 Each channel SHALL hold a stable level (drives db[i]) and a 3-bit count.
REQ-016 When sw[i] equals db[i], count SHALL be cleared to 0 in the next cycle, regardless of tick.
REQ-017 When sw[i] differs from db[i] and tick=1, count SHALL increment; on the tick where count would reach DB_TICKS, db[i] SHALL toggle at that clock edge, count SHALL clear, and pending[i] SHALL set with pend_dir[i] = new db[i].
REQ-018 A mismatch present on fewer than DB_TICKS ticks SHALL leave db[i] unchanged; a single matching cycle SHALL restart qualification.
REQ-019 The output stage SHALL be a one-entry register: ev_valid, ev_id and ev_rise SHALL stay constant while ev_valid=1 and ev_ready=0.
REQ-020 A transfer SHALL occur on a cycle with ev_valid=1 and ev_ready=1; ev_valid SHALL drop the next cycle unless a new grant loads it.
REQ-021 The arbiter SHALL grant one pending channel per cycle when the output register is empty or transferring, loading it at that edge (back-to-back events permitted, 1 event/cycle max).
REQ-022 Arbitration SHALL be round-robin: search starts at last-granted index + 1 modulo N_BTN; the last-granted pointer resets to N_BTN-1, so channel 0 has first priority.
REQ-023 The granted channel's pending bit SHALL clear at the load edge; if the same channel qualifies a new edge in that same cycle, pending SHALL remain set with the new direction.
REQ-024 If a channel qualifies an edge while its pending bit is already set, pend_dir SHALL be overwritten with the latest direction and ovf SHALL set.
REQ-025 Latency: ev_valid SHALL assert no earlier than 1 cycle after the db[i] toggle edge.
REQ-026 ovf_clr=1 SHALL clear ovf the next cycle; a simultaneous overflow event SHALL take priority (ovf remains 1).
REQ-027 ev_ready SHALL be ignored while ev_valid=0.

Reset
REQ-028 While reset=1, the tick counter, all counts, pending bits, pointer state and ovf SHALL be 0, db SHALL be all zeros, and ev_valid, ev_id and ev_rise SHALL be 0.
REQ-029 Reset asserted mid-qualification or with an event held SHALL discard that event with no output.
REQ-030 After release, the first tick SHALL occur in the first cycle, because the counter equals 0.

Configuration
REQ-031 With macro BTN_EVENT_OVF_EN defined, REQ-024 and REQ-026 ovf behaviour SHALL be compiled in.
REQ-032 Without BTN_EVENT_OVF_EN, ovf SHALL be constant 0, ovf_clr SHALL be ignored, and pend_dir overwrite SHALL still occur.

Verification (TICK_BITS=4, DB_TICKS=3, N_BTN=4; tick every 16 cycles)
REQ-033 The bench SHALL cover this scenario: sw[0] goes 0->1 and is held -> db[0] rises at the 3rd tick edge; one event is issued with ev_id=0, ev_rise=1, and ev_valid=1 on the following cycle.
REQ-034 The bench SHALL cover this scenario: sw[1] is high across 2 ticks, then low for 1 cycle, then high -> db[1] does not rise until 3 further consecutive ticks.
REQ-035 The bench SHALL cover this scenario: sw[3:0] all go 0->1 on the same cycle with ev_ready=1 -> 4 events arrive on consecutive cycles with ev_id 0,1,2,3.
REQ-036 The bench SHALL cover this scenario: ev_ready=0 is held for 100 cycles during an event -> ev_id and ev_rise are stable throughout, and exactly one transfer occurs on ready.
REQ-037 The bench SHALL cover this scenario: ev_ready=0 while channel 2 presses and then releases (both qualified) -> ovf=1, the pending event has ev_rise=0, and ovf_clr clears it.
REQ-038 The bench SHALL cover this scenario: reset is pulsed during count=2 with an event held -> all outputs are 0, and no event appears after release.

Source files
------------

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl
//   Debounces N_BTN synchronised switch inputs against a shared sample tick
//   and reports every qualified level change as an event through a one-entry
//   valid/ready output register. Pending channels are served round-robin.
//
//   Optional feature: define BTN_EVENT_OVF_EN to build the sticky lost-event
//   flag (ovf). Without it ovf is tied to 0 and ovf_clr is ignored.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   sw        in   [N_BTN] raw switch levels, already synchronised to clk
//   db        out  [N_BTN] debounced levels
//   ev_valid  out  event available
//   ev_ready  in   consumer accepts event (ignored while ev_valid=0)
//   ev_id     out  [2] channel index of the event
//   ev_rise   out  1 = press (0->1), 0 = release (1->0)
//   ovf_clr   in   clears ovf
//   ovf       out  sticky flag: an unreported edge was overwritten
module btn_event_ctrl #(
  parameter int N_BTN     = 4,
  parameter int TICK_BITS = 19,
  parameter int DB_TICKS  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] sw,
  output logic [N_BTN-1:0] db,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [1:0]       ev_id,
  output logic             ev_rise,
  input  logic             ovf_clr,
  output logic             ovf
);

  logic [TICK_BITS-1:0] tick_cnt;
  logic                 tick;
  logic [2:0]           cnt [N_BTN];
  logic [N_BTN-1:0]     mism;
  logic [N_BTN-1:0]     qual;
  logic [N_BTN-1:0]     pending;
  logic [N_BTN-1:0]     pend_dir;

  // rr_ptr holds the index where the next search starts (last grant + 1),
  // so its reset value of 0 gives channel 0 first priority.
  logic [1:0]           rr_ptr;
  logic [1:0]           nxt_ptr;
  logic [2*N_BTN-1:0]   pend2;
  logic [N_BTN-1:0]     rot;
  logic [2:0]           sum3;
  logic                 gnt_found;
  logic [1:0]           gnt_idx;
  logic [N_BTN-1:0]     gnt_oh;
  logic                 load;
  logic                 ovf_set;

  assign tick = (tick_cnt == '0);

  // A channel qualifies on the tick where its mismatch count would reach
  // DB_TICKS.
  always_comb begin
    mism = '0;
    qual = '0;
    for (int i = 0; i < N_BTN; i++) begin
      mism[i] = sw[i] ^ db[i];
      qual[i] = mism[i] & tick & (cnt[i] == 3'(DB_TICKS - 1));
    end
  end

  // Rotate the pending vector so the search start lands at bit 0, take the
  // lowest set bit, then rotate the index back.
  always_comb begin
    pend2     = {pending, pending};
    rot       = N_BTN'(pend2 >> rr_ptr);
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum3      = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum3 = {1'b0, rr_ptr} + 3'(k);
        if (sum3 >= 3'(N_BTN)) sum3 = sum3 - 3'(N_BTN);
        gnt_idx   = sum3[1:0];
        gnt_found = 1'b1;
      end
    end
    load    = gnt_found & (~ev_valid | ev_ready);
    gnt_oh  = load ? (N_BTN'(1) << gnt_idx) : '0;
    nxt_ptr = (({1'b0, gnt_idx} + 3'd1) >= 3'(N_BTN)) ? 2'd0 : gnt_idx + 2'd1;
    // An edge is lost only if the older pending one is not leaving this cycle.
    ovf_set = |(qual & pending & ~gnt_oh);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      db       <= '0;
      pending  <= '0;
      pend_dir <= '0;
      rr_ptr   <= '0;
      ev_valid <= 1'b0;
      ev_id    <= '0;
      ev_rise  <= 1'b0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_BITS'(1);

      for (int i = 0; i < N_BTN; i++) begin
        if (!mism[i]) begin
          cnt[i] <= '0;
        end else if (qual[i]) begin
          cnt[i] <= '0;
          db[i]  <= ~db[i];
        end else if (tick) begin
          cnt[i] <= cnt[i] + 3'd1;
        end
      end

      // A new qualification wins over the grant clear, keeping the fresh
      // direction pending.
      pending  <= (pending & ~gnt_oh) | qual;
      pend_dir <= (pend_dir & ~qual) | (~db & qual);

      if (load) begin
        ev_valid <= 1'b1;
        ev_id    <= gnt_idx;
        ev_rise  <= |(pend_dir & gnt_oh);
        rr_ptr   <= nxt_ptr;
      end else if (ev_ready) begin
        ev_valid <= 1'b0;
      end
    end
  end

`ifdef BTN_EVENT_OVF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end
`else
  logic unused_ovf;
  assign ovf        = 1'b0;
  assign unused_ovf = ovf_clr ^ ovf_set;
`endif

endmodule
